hilo_ctrl: RTL and testbench

Sequencer between the two EX issue slots and the HI/LO register file of the dual-issue core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from either slot and runs multiply (pipelined) and divide (iterative). Emits one registered HI/LO write pulse per operation toward the HI/LO register's slot-1 write port. Serialises same-bundle requests from both slots and stalls the pipeline while busy.

---
 rtl/hilo_ctrl_pkg.sv | 57 +++++
 rtl/hilo_ctrl_if.sv | 29 ++
 rtl/hilo_ctrl_div_iter.sv | 66 ++++++
 rtl/hilo_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_hilo_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer: op codes, FSM states, latencies and
// op-class decode helpers.
package hilo_ctrl_pkg;

    localparam int unsigned HILO_W    = 32;
    localparam int unsigned DIV_LAT   = 34;
    localparam int unsigned DIV_ITERS = DIV_LAT - 2;

    typedef enum logic [2:0] {
        HILO_NOP   = 3'd0,
        HILO_MULT  = 3'd1,
        HILO_MULTU = 3'd2,
        HILO_DIV   = 3'd3,
        HILO_DIVU  = 3'd4,
        HILO_MTHI  = 3'd5,
        HILO_MTLO  = 3'd6
    } hilo_op_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMtx  = 3'd1,
        StMul  = 3'd2,
        StDiv  = 3'd3,
        StWb   = 3'd4
    } hilo_state_e;

    typedef struct packed {
        logic [2:0]        op;
        logic [HILO_W-1:0] rs;
        logic [HILO_W-1:0] rt;
    } hilo_req_t;

    function automatic logic op_is_req(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd6);
    endfunction

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == HILO_MULT) || (op == HILO_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == HILO_MULT) || (op == HILO_DIV);
    endfunction

    // MTHI/MTLO write back one cycle after accept, so they go straight to WB.
    function automatic hilo_state_e op_next_state(input logic [2:0] op);
        if (op_is_mul(op)) return StMul;
        if (op_is_div(op)) return StDiv;
        if ((op == HILO_MTHI) || (op == HILO_MTLO)) return StWb;
        return StIdle;
    endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// Issue-slot request and HI/LO write-port bundle between the EX stage and hilo_ctrl.
interface hilo_ctrl_if;
    import hilo_ctrl_pkg::*;

    logic              flush;
    logic [2:0]        op_i1;
    logic [HILO_W-1:0] rs_i1;
    logic [HILO_W-1:0] rt_i1;
    logic [2:0]        op_i2;
    logic [HILO_W-1:0] rs_i2;
    logic [HILO_W-1:0] rt_i2;
    logic              hi_we;
    logic              lo_we;
    logic [HILO_W-1:0] hi_o;
    logic [HILO_W-1:0] lo_o;
    logic              stall;
    logic              busy;

    modport master (
        output flush, op_i1, rs_i1, rt_i1, op_i2, rs_i2, rt_i2,
        input  hi_we, lo_we, hi_o, lo_o, stall, busy
    );

    modport slave (
        input  flush, op_i1, rs_i1, rt_i1, op_i2, rs_i2, rt_i2,
        output hi_we, lo_we, hi_o, lo_o, stall, busy
    );

endinterface

// File: rtl/hilo_ctrl_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle; o_done pulses the cycle
// after the last iteration with quotient/remainder valid.
module hilo_ctrl_div_iter
    import hilo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quo,
    output logic [DATA_W-1:0] o_rem
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    logic              r_busy;
    logic              r_done;
    logic [CntW-1:0]   r_cnt;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_div;

    logic [DATA_W:0]   w_shift;
    logic [DATA_W+1:0] w_diff;
    logic              w_neg;

    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_div};
    assign w_neg   = w_diff[DATA_W+1];

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= CntW'(DATA_W);
                r_quo  <= i_dividend;
                r_rem  <= '0;
                r_div  <= i_divisor;
            end else if (r_busy) begin
                // Zero divisor never goes negative: quotient fills with ones, remainder = dividend.
                r_quo <= {r_quo[DATA_W-2:0], ~w_neg};
                r_rem <= w_neg ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
                r_cnt <= r_cnt - CntW'(1);
                if (r_cnt == CntW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_quo  = r_quo;
    assign o_rem  = r_rem;

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: serialises MULT/DIV/MTx requests from both issue slots and emits
// one registered HI/LO write pulse per op, stalling the pipeline while busy.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    hilo_ctrl_if.slave hl
);

    localparam int unsigned MulStages = MUL_LAT - 1;
    localparam int unsigned CntW      = $clog2(MUL_LAT) + 1;

    hilo_state_e r_state;
    hilo_state_e w_state_nxt;

    logic      w_req1;
    logic      w_req2;
    hilo_req_t w_slot1;
    hilo_req_t w_slot2;
    hilo_req_t w_sel;
    hilo_req_t w_st;
    hilo_req_t r_pend;
    logic      r_pend_v;
    logic      w_start;

    assign w_req1  = op_is_req(hl.op_i1);
    assign w_req2  = op_is_req(hl.op_i2);
    assign w_slot1 = {hl.op_i1, hl.rs_i1, hl.rt_i1};
    assign w_slot2 = {hl.op_i2, hl.rs_i2, hl.rt_i2};
    assign w_sel   = w_req1 ? w_slot1 : w_slot2;

    // An op starts either from the slots in IDLE or from pending during WB.
    assign w_st    = (r_state == StWb) ? r_pend : w_sel;
    assign w_start = !hl.flush &&
                     (((r_state == StIdle) && (w_req1 || w_req2)) ||
                      ((r_state == StWb) && r_pend_v));

    always_ff @(posedge clk) begin
        if (rst || hl.flush) begin
            r_pend_v <= 1'b0;
            r_pend   <= '0;
        end else if ((r_state == StIdle) && w_req1 && w_req2) begin
            r_pend_v <= 1'b1;
            r_pend   <= w_slot2;
        end else if (r_state == StWb) begin
            r_pend_v <= 1'b0;
        end
    end

    logic              w_sgn;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [2*DATA_W-1:0] w_mul_a;
    logic [2*DATA_W-1:0] w_mul_b;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] r_mul_pipe [MulStages];
    logic [CntW-1:0]     r_mul_cnt;

    assign w_sgn   = op_is_signed(w_st.op);
    assign w_a_neg = w_sgn & w_st.rs[DATA_W-1];
    assign w_b_neg = w_sgn & w_st.rt[DATA_W-1];
    assign w_mul_a = {{DATA_W{w_a_neg}}, w_st.rs};
    assign w_mul_b = {{DATA_W{w_b_neg}}, w_st.rt};
    assign w_prod  = w_mul_a * w_mul_b;

    always_ff @(posedge clk) begin
        if (w_start && op_is_mul(w_st.op)) begin
            r_mul_pipe[0] <= w_prod;
            r_mul_cnt     <= CntW'(MUL_LAT - 2);
        end else if (r_state == StMul) begin
            r_mul_cnt <= r_mul_cnt - CntW'(1);
        end
        for (int i = 1; i < MulStages; i++) begin
            r_mul_pipe[i] <= r_mul_pipe[i-1];
        end
    end

    logic              w_div_start;
    logic              w_div_done;
    logic [DATA_W-1:0] w_div_a;
    logic [DATA_W-1:0] w_div_b;
    logic [DATA_W-1:0] w_div_quo;
    logic [DATA_W-1:0] w_div_rem;
    logic              r_q_neg;
    logic              r_r_neg;

    assign w_div_start = w_start && op_is_div(w_st.op);
    assign w_div_a     = w_a_neg ? -w_st.rs : w_st.rs;
    assign w_div_b     = w_b_neg ? -w_st.rt : w_st.rt;

    always_ff @(posedge clk) begin
        if (w_div_start) begin
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
        end
    end

    hilo_ctrl_div_iter #(
        .DATA_W(DATA_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_div_start),
        .i_abort   (hl.flush),
        .i_dividend(w_div_a),
        .i_divisor (w_div_b),
        .o_done    (w_div_done),
        .o_quo     (w_div_quo),
        .o_rem     (w_div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_start) w_state_nxt = op_next_state(w_st.op);
            StMul:   if (r_mul_cnt == '0) w_state_nxt = StWb;
            StDiv:   if (w_div_done) w_state_nxt = StWb;
            StWb:    w_state_nxt = w_start ? op_next_state(w_st.op) : StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (hl.flush) w_state_nxt = StIdle;
    end

    logic              w_hi_we;
    logic              w_lo_we;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;
    logic              w_stall;
    logic              w_busy;
    logic              r_hi_we;
    logic              r_lo_we;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    always_comb begin
        w_hi_we = 1'b0;
        w_lo_we = 1'b0;
        w_hi    = r_hi;
        w_lo    = r_lo;
        if (w_start && (w_st.op == HILO_MTHI)) begin
            w_hi_we = 1'b1;
            w_hi    = w_st.rs;
        end
        if (w_start && (w_st.op == HILO_MTLO)) begin
            w_lo_we = 1'b1;
            w_lo    = w_st.rs;
        end
        if (!hl.flush && (r_state == StMul) && (r_mul_cnt == '0)) begin
            w_hi_we      = 1'b1;
            w_lo_we      = 1'b1;
            {w_hi, w_lo} = r_mul_pipe[MulStages-1];
        end
        if (!hl.flush && (r_state == StDiv) && w_div_done) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_lo    = r_q_neg ? -w_div_quo : w_div_quo;
            w_hi    = r_r_neg ? -w_div_rem : w_div_rem;
        end
        if (r_state == StIdle) begin
            w_stall = !hl.flush && (w_req1 || w_req2) &&
                      ((w_req1 && w_req2) || op_is_mul(w_sel.op) || op_is_div(w_sel.op));
        end else begin
            w_stall = (r_state != StWb) || r_pend_v;
        end
        w_busy = (r_state != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_we <= 1'b0;
            r_lo_we <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_hi_we <= w_hi_we;
            r_lo_we <= w_lo_we;
            r_hi    <= w_hi;
            r_lo    <= w_lo;
        end
    end

    assign hl.hi_we = r_hi_we;
    assign hl.lo_we = r_lo_we;
    assign hl.hi_o  = r_hi;
    assign hl.lo_o  = r_lo;
    assign hl.stall = w_stall;
    assign hl.busy  = w_busy;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed self-checking bench for hilo_ctrl: multiply/divide results, pulse timing,
// slot serialisation, divide-by-zero, flush and mid-op reset.
module tb_hilo_ctrl;
    import hilo_ctrl_pkg::*;

    localparam int unsigned MulLat = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hilo_ctrl_if hl_bus();

    hilo_ctrl #(
        .DATA_W (32),
        .MUL_LAT(MulLat)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .hl (hl_bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        hl_bus.flush = 1'b0;
        hl_bus.op_i1 = HILO_NOP;
        hl_bus.rs_i1 = '0;
        hl_bus.rt_i1 = '0;
        hl_bus.op_i2 = HILO_NOP;
        hl_bus.rs_i2 = '0;
        hl_bus.rt_i2 = '0;
    endtask

    task automatic issue(input logic [2:0] op1, input logic [31:0] rs1, input logic [31:0] rt1,
                         input logic [2:0] op2, input logic [31:0] rs2, input logic [31:0] rt2);
        @(negedge clk);
        clear_inputs();
        hl_bus.op_i1 = op1;
        hl_bus.rs_i1 = rs1;
        hl_bus.rt_i1 = rt1;
        hl_bus.op_i2 = op2;
        hl_bus.rs_i2 = rs2;
        hl_bus.rt_i2 = rt2;
        #1;
    endtask

    task automatic quiet(input string tag, input int n, input logic st);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_inputs();
            #1;
            check_eq({tag, "_stall"}, 64'(hl_bus.stall), 64'(st));
            check_eq({tag, "_we"}, {62'b0, hl_bus.hi_we, hl_bus.lo_we}, 64'd0);
        end
    endtask

    task automatic pulse(input string tag, input logic [1:0] we, input logic [31:0] hi,
                         input logic [31:0] lo, input logic st);
        @(negedge clk);
        clear_inputs();
        #1;
        if (we[1]) m_hi = hi;
        if (we[0]) m_lo = lo;
        check_eq({tag, "_we"}, {62'b0, hl_bus.hi_we, hl_bus.lo_we}, {62'b0, we});
        check_eq({tag, "_hi"}, 64'(hl_bus.hi_o), 64'(m_hi));
        check_eq({tag, "_lo"}, 64'(hl_bus.lo_o), 64'(m_lo));
        check_eq({tag, "_stall"}, 64'(hl_bus.stall), 64'(st));
    endtask

    // Single slot-1 MULT/DIV: stall in the accept cycle, quiet until the pulse.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int quiet_n,
                          input logic [31:0] hi, input logic [31:0] lo);
        issue(op, rs, rt, HILO_NOP, 32'd0, 32'd0);
        check_eq({tag, "_stall_t"}, 64'(hl_bus.stall), 64'd1);
        quiet(tag, quiet_n, 1'b1);
        pulse(tag, 2'b11, hi, lo, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_we", {62'b0, hl_bus.hi_we, hl_bus.lo_we}, 64'd0);
        check_eq("rst_hi", 64'(hl_bus.hi_o), 64'd0);
        check_eq("rst_lo", 64'(hl_bus.lo_o), 64'd0);
        check_eq("rst_stall", 64'(hl_bus.stall), 64'd0);
        check_eq("rst_busy", 64'(hl_bus.busy), 64'd0);
        rst = 1'b0;

        run_op("mult", HILO_MULT, 32'hFFFF_FFFF, 32'd2, MulLat - 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", HILO_MULTU, 32'hFFFF_FFFF, 32'd2, MulLat - 1, 32'h0000_0001,
               32'hFFFF_FFFE);
        run_op("mult_nn", HILO_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, MulLat - 1, 32'd0, 32'd15);

        issue(HILO_NOP, 32'd0, 32'd0, HILO_MULTU, 32'h0001_0000, 32'h0001_0000);
        check_eq("slot2_stall_t", 64'(hl_bus.stall), 64'd1);
        quiet("slot2", MulLat - 1, 1'b1);
        pulse("slot2", 2'b11, 32'd1, 32'd0, 1'b0);

        run_op("div_neg", HILO_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT - 1, 32'hFFFF_FFFF,
               32'hFFFF_FFFD);
        run_op("div_negb", HILO_DIV, 32'd7, 32'hFFFF_FFFE, DIV_LAT - 1, 32'd1, 32'hFFFF_FFFD);

        issue(HILO_DIVU, 32'd100, 32'd7, HILO_MTHI, 32'h1234, 32'd0);
        check_eq("pair_stall_t", 64'(hl_bus.stall), 64'd1);
        quiet("pair", DIV_LAT - 1, 1'b1);
        pulse("pair_div", 2'b11, 32'd2, 32'd14, 1'b1);
        pulse("pair_mthi", 2'b10, 32'h1234, 32'd0, 1'b0);

        run_op("divu_z", HILO_DIVU, 32'd5, 32'd0, DIV_LAT - 1, 32'd5, 32'hFFFF_FFFF);
        run_op("div_z", HILO_DIV, 32'hFFFF_FFF9, 32'd0, DIV_LAT - 1, 32'hFFFF_FFF9, 32'd1);

        issue(HILO_MTHI, 32'hCAFE, 32'd0, HILO_NOP, 32'd0, 32'd0);
        check_eq("mthi_stall_t", 64'(hl_bus.stall), 64'd0);
        pulse("mthi", 2'b10, 32'hCAFE, 32'd0, 1'b0);

        issue(HILO_MTHI, 32'hAAAA, 32'd0, HILO_MTLO, 32'hBBBB, 32'd0);
        check_eq("mtx2_stall_t", 64'(hl_bus.stall), 64'd1);
        pulse("mtx2_hi", 2'b10, 32'hAAAA, 32'd0, 1'b1);
        pulse("mtx2_lo", 2'b01, 32'd0, 32'hBBBB, 1'b0);

        issue(HILO_DIV, 32'd100, 32'd3, HILO_NOP, 32'd0, 32'd0);
        check_eq("flush_stall_t", 64'(hl_bus.stall), 64'd1);
        quiet("flush_run", 9, 1'b1);
        @(negedge clk);
        clear_inputs();
        hl_bus.flush = 1'b1;
        #1;
        check_eq("flush_we", {62'b0, hl_bus.hi_we, hl_bus.lo_we}, 64'd0);
        @(negedge clk);
        clear_inputs();
        hl_bus.op_i1 = HILO_MTLO;
        hl_bus.rs_i1 = 32'hA5;
        #1;
        check_eq("flush_idle_stall", 64'(hl_bus.stall), 64'd0);
        check_eq("flush_idle_busy", 64'(hl_bus.busy), 64'd0);
        check_eq("flush_idle_we", {62'b0, hl_bus.hi_we, hl_bus.lo_we}, 64'd0);
        pulse("flush_mtlo", 2'b01, 32'd0, 32'hA5, 1'b0);
        quiet("flush_after", 40, 1'b0);

        issue(HILO_MULTU, 32'd3, 32'd5, HILO_NOP, 32'd0, 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rstmid_we", {62'b0, hl_bus.hi_we, hl_bus.lo_we}, 64'd0);
        check_eq("rstmid_hi", 64'(hl_bus.hi_o), 64'd0);
        check_eq("rstmid_lo", 64'(hl_bus.lo_o), 64'd0);
        check_eq("rstmid_busy", 64'(hl_bus.busy), 64'd0);
        m_hi = '0;
        m_lo = '0;
        rst  = 1'b0;
        issue(HILO_MTLO, 32'h77, 32'd0, HILO_NOP, 32'd0, 32'd0);
        pulse("post_rst", 2'b01, 32'd0, 32'h77, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
